// File: rtl/ai_move_responder.sv
// Opponent move selector for the battle controller.
// On a four-phase request it latches HP and PP availability, prefers the heal
// move when HP is low, otherwise scans candidates starting at a pseudo-random
// index, and falls back to struggle when nothing is usable.
module ai_move_responder (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic [7:0] ai_hp,
    input  logic [3:0] move_ready,
    output logic       ack,
    output logic [1:0] move_id,
    output logic [7:0] move_power,
    output logic       no_move
);

    localparam logic [7:0] HealHp        = 8'd32;
    localparam logic [7:0] StrugglePower = 8'd20;
    localparam logic [1:0] HealMove      = 2'd3;

    typedef enum logic [1:0] {StIdle, StLatch, StScan, StHold} state_e;

    state_e     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] hp_q, hp_d;
    logic [3:0] ready_q, ready_d;
    logic [1:0] cand_q, cand_d;
    logic [1:0] tries_q, tries_d;
    logic [1:0] id_q, id_d;
    logic [7:0] power_q, power_d;
    logic       no_move_q, no_move_d;
    logic       eligible;

    function automatic logic [7:0] power_of(input logic [1:0] id);
        case (id)
            2'd0:    power_of = 8'd40;
            2'd1:    power_of = 8'd60;
            2'd2:    power_of = 8'd90;
            default: power_of = 8'd0;
        endcase
    endfunction

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Heal is only usable as a scan candidate while HP is low.
    always_comb begin
        eligible = ready_q[cand_q] && !((cand_q == HealMove) && (hp_q > HealHp));
    end

    // Next-state and selection logic.
    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        ready_d   = ready_q;
        cand_d    = cand_q;
        tries_d   = tries_q;
        id_d      = id_q;
        power_d   = power_q;
        no_move_d = no_move_q;
        unique case (state_q)
            StIdle: begin
                if (req) state_d = StLatch;
            end
            StLatch: begin
                hp_d      = ai_hp;
                ready_d   = move_ready;
                cand_d    = lfsr_q[1:0];
                tries_d   = 2'd0;
                no_move_d = 1'b0;
                if ((ai_hp <= HealHp) && move_ready[3]) begin
                    id_d    = HealMove;
                    power_d = power_of(HealMove);
                    state_d = StHold;
                end else begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (eligible) begin
                    id_d    = cand_q;
                    power_d = power_of(cand_q);
                    state_d = StHold;
                end else if (tries_q == 2'd3) begin
                    // Fourth miss: every candidate was rejected.
                    no_move_d = 1'b1;
                    id_d      = 2'd0;
                    power_d   = StrugglePower;
                    state_d   = StHold;
                end else begin
                    cand_d  = cand_q + 2'd1;
                    tries_d = tries_q + 2'd1;
                end
            end
            StHold: begin
                if (!req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            lfsr_q    <= 8'hA5;
            hp_q      <= 8'd0;
            ready_q   <= 4'd0;
            cand_q    <= 2'd0;
            tries_q   <= 2'd0;
            id_q      <= 2'd0;
            power_q   <= 8'd0;
            no_move_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            hp_q      <= hp_d;
            ready_q   <= ready_d;
            cand_q    <= cand_d;
            tries_q   <= tries_d;
            id_q      <= id_d;
            power_q   <= power_d;
            no_move_q <= no_move_d;
        end
    end

    // Outputs come straight from registers; ack only in HOLD.
    always_comb begin
        ack        = (state_q == StHold);
        move_id    = id_q;
        move_power = power_q;
        no_move    = no_move_q;
    end

endmodule

// File: tb/tb_ai_move_responder.sv
// Self-checking bench for ai_move_responder: directed scenarios plus random
// requests checked against a behavioural selection model.
module tb_ai_move_responder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req = 1'b0;
    logic [7:0] ai_hp = 8'd0;
    logic [3:0] move_ready = 4'd0;
    logic       ack;
    logic [1:0] move_id;
    logic [7:0] move_power;
    logic       no_move;

    int tests_run = 0;
    int tests_failed = 0;
    int pwr_tab[4] = '{40, 60, 90, 0};
    int id_count[4] = '{0, 0, 0, 0};

    // Reference copy of the pseudo-random source, kept as a polynomial mask.
    logic [7:0] m_lfsr;

    ai_move_responder dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .ai_hp      (ai_hp),
        .move_ready (move_ready),
        .ack        (ack),
        .move_id    (move_id),
        .move_power (move_power),
        .no_move    (no_move)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!resetn) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected result from the selection rules: heal first, then the first
    // usable move starting at the random candidate, else struggle.
    task automatic model_pick(input logic [7:0] hp, input logic [3:0] rdy, input int cand,
                              output logic nm, output int id, output int pw, output int lat);
        nm  = 1'b1;
        id  = 0;
        pw  = 20;
        lat = 6;
        if (hp <= 32 && rdy[3]) begin
            nm = 1'b0; id = 3; pw = 0; lat = 2;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (cand + k - 1) % 4;
                if (rdy[c] && !(c == 3 && hp > 32)) begin
                    nm = 1'b0; id = c; pw = pwr_tab[c]; lat = 2 + k;
                    break;
                end
            end
        end
    endtask

    // One full request. drop: req released right after the sample.
    // scramble: inputs change once LATCH has passed.
    task automatic run_req(input string tag, input logic [7:0] hp, input logic [3:0] rdy,
                           input bit drop, input bit scramble, output int got_id);
        int   n;
        int   cand;
        logic e_nm;
        int   e_id, e_pw, e_lat;
        bit   seen;
        @(negedge clk);
        ai_hp = hp;
        move_ready = rdy;
        req = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        cand = 0;
        for (n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cand = int'(m_lfsr[1:0]);
                if (drop) req = 1'b0;
            end
            if (n == 2 && scramble) begin
                move_ready = ~rdy;
                ai_hp = ~hp;
            end
            if (ack === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        model_pick(hp, rdy, cand, e_nm, e_id, e_pw, e_lat);
        check({tag, " ack_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(e_lat));
        check({tag, " move_id"}, 32'(move_id), 32'(e_id));
        check({tag, " move_power"}, 32'(move_power), 32'(e_pw));
        check({tag, " no_move"}, 32'(no_move), 32'(e_nm));
        got_id = int'(move_id);
        if (!drop) begin
            repeat (2) @(negedge clk);
            check({tag, " hold_ack"}, 32'(ack), 32'd1);
            check({tag, " hold_id"}, 32'(move_id), 32'(e_id));
            req = 1'b0;
        end
        @(negedge clk);
        check({tag, " ack_drop"}, 32'(ack), 32'd0);
        check({tag, " idle_power"}, 32'(move_power), 32'(e_pw));
    endtask

    initial begin
        int id;
        bit saw_ack;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst ack", 32'(ack), 32'd0);
        check("rst move_id", 32'(move_id), 32'd0);
        check("rst move_power", 32'(move_power), 32'd0);
        check("rst no_move", 32'(no_move), 32'd0);
        resetn = 1'b1;

        // Directed scenarios.
        run_req("single", 8'd200, 4'b0100, 1'b0, 1'b0, id);
        check("single id2", 32'(id), 32'd2);
        run_req("heal", 8'd30, 4'b1111, 1'b0, 1'b0, id);
        check("heal id3", 32'(id), 32'd3);
        run_req("heal_edge", 8'd32, 4'b1000, 1'b0, 1'b0, id);
        check("heal_edge id3", 32'(id), 32'd3);
        run_req("exhaust", 8'd100, 4'b1000, 1'b0, 1'b0, id);
        check("exhaust no_move", 32'(no_move), 32'd1);
        run_req("freeze", 8'd200, 4'b0010, 1'b0, 1'b1, id);
        check("freeze id1", 32'(id), 32'd1);
        run_req("early_drop", 8'd200, 4'b0001, 1'b1, 1'b0, id);
        check("early_drop id0", 32'(id), 32'd0);

        // Random requests across HP, readiness and handshake variations.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] hp;
            hp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40))
                                             : 8'($urandom_range(0, 255));
            run_req("rand", hp, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), id);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Distribution with heal ineligible.
        for (int i = 0; i < 64; i++) begin
            run_req("dist", 8'd200, 4'b0111, 1'b0, 1'b0, id);
            id_count[id]++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check("dist id0 seen", 32'(id_count[0] > 0), 32'd1);
        check("dist id1 seen", 32'(id_count[1] > 0), 32'd1);
        check("dist id2 seen", 32'(id_count[2] > 0), 32'd1);
        check("dist id3 never", 32'(id_count[3]), 32'd0);

        // Reset in the middle of a scan, with req still asserted (reset wins).
        @(negedge clk);
        ai_hp = 8'd100;
        move_ready = 4'b0000;
        req = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midscan_rst ack", 32'(ack), 32'd0);
        check("midscan_rst move_id", 32'(move_id), 32'd0);
        check("midscan_rst move_power", 32'(move_power), 32'd0);
        check("midscan_rst no_move", 32'(no_move), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_prio ack", 32'(ack), 32'd0);
        req = 1'b0;
        resetn = 1'b1;
        saw_ack = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        check("post_rst idle", 32'(saw_ack), 32'd0);
        run_req("post_rst", 8'd10, 4'b1001, 1'b0, 1'b0, id);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
